pulse_width_meter: RTL

Consumer of the 1 ms enable tick from the sensor clock divider. Times the high phase of an asynchronous sensor line (e.g. echo or break-beam output) in whole milliseconds and returns the result to the key-detect logic over a valid/ack handshake. Measures once per start request and flags a timeout when no pulse arrives or the pulse runs too long.

---
 rtl/pulse_width_meter_if.sv | 11 +
 rtl/pulse_width_meter.sv | 90 +++++++++
 2 files changed

// File: rtl/pulse_width_meter_if.sv
// pulse_width_meter_if: start/ack request side and registered result side of the pulse width meter
interface pulse_width_meter_if #(parameter int COUNT_WIDTH = 16);
  logic start;
  logic ack;
  logic busy;
  logic valid;
  logic timeout;
  logic [COUNT_WIDTH-1:0] width_ms;
  modport master(output start, ack, input busy, valid, timeout, width_ms);
  modport slave(input start, ack, output busy, valid, timeout, width_ms);
endinterface

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: times the high phase of an async sensor line in 1 ms ticks, one result per start
module pulse_width_meter #(
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT_MS  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_1ms,
  input  logic sig_in,
  pulse_width_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;
  localparam logic [COUNT_WIDTH-1:0] TMO = COUNT_WIDTH'(TIMEOUT_MS);
  state_t state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [COUNT_WIDTH-1:0] wait_q, wait_d, hi_q, hi_d, width_q, width_d, wait_inc, hi_inc;
  logic timeout_q, timeout_d, busy_q, busy_d, valid_q, valid_d;
  logic rise, fall;
  // sync_q[1] is the synchronised line, sync_q[2] its one-clk-old copy
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];
  assign wait_inc = wait_q + COUNT_WIDTH'(tick_1ms);
  assign hi_inc = hi_q + COUNT_WIDTH'(tick_1ms);
  always_comb begin
    sync_d = {sync_q[1:0], sig_in};
    state_d = state_q;
    wait_d = wait_q;
    hi_d = hi_q;
    width_d = width_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = ARMED;
        wait_d = '0;
        hi_d = '0;
        width_d = '0;
        timeout_d = 1'b0;
      end
      ARMED: begin
        wait_d = wait_inc;
        if (rise) state_d = MEASURE;
        else if (wait_inc == TMO) begin
          state_d = DONE;
          timeout_d = 1'b1;
          width_d = '0;
        end
      end
      MEASURE: begin
        hi_d = hi_inc;
        if (fall) begin
          state_d = DONE;
          width_d = hi_inc;
        end else if (hi_inc == TMO) begin
          state_d = DONE;
          timeout_d = 1'b1;
          width_d = TMO;
        end
      end
      DONE: state_d = bus.ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ARMED) || (state_d == MEASURE);
    valid_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync_q <= '0;
      wait_q <= '0;
      hi_q <= '0;
      width_q <= '0;
      timeout_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      wait_q <= wait_d;
      hi_q <= hi_d;
      width_q <= width_d;
      timeout_q <= timeout_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.valid = valid_q;
  assign bus.width_ms = width_q;
  assign bus.timeout = timeout_q;
endmodule
